// File: rtl/timer_cap_cmp_chn.sv
// One capture/compare channel fed by the shared basic timer.
// Compare mode drives a PWM output and match pulse; capture mode latches the count on a filtered pin edge.
module timer_cap_cmp_chn #(
  parameter int timer_width      = 16,
  parameter int filter_width     = 8,
  parameter int simulation_delay = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    timer_started,
  input  logic                    timer_expired,
  input  logic [timer_width-1:0]  timer_cnt_now_v,
  input  logic                    cap_cmp_sel,
  input  logic [timer_width-1:0]  cmp_value,
  input  logic                    cmp_polarity,
  input  logic                    cap_in,
  input  logic [1:0]              cap_edge_type,
  input  logic [filter_width-1:0] cap_filter_th,
  input  logic                    cap_clr,
  output logic                    cmp_out,
  output logic [timer_width-1:0]  cap_value,
  output logic                    cap_pending,
  output logic                    cap_ovr,
  output logic                    cmp_itr_req,
  output logic                    cap_itr_req
);

  // simulation_delay is kept for drop-in compatibility; no delay is modelled here.
  if (simulation_delay < 0) begin : g_neg_delay
  end

  logic [timer_width-1:0]  cmp_shadow_q, cmp_shadow_d;
  logic                    cmp_out_q, cmp_out_d;
  logic                    match_q, match_d;
  logic                    cmp_itr_q, cmp_itr_d;
  logic                    s1_q, s1_d, s2_q, s2_d;
  logic [filter_width-1:0] fcnt_q, fcnt_d;
  logic                    filt_lvl_q, filt_lvl_d;
  logic [timer_width-1:0]  cap_value_q, cap_value_d;
  logic                    cap_pending_q, cap_pending_d;
  logic                    cap_ovr_q, cap_ovr_d;
  logic                    cap_itr_q, cap_itr_d;
  logic                    toggle, edge_hit, cap_evt;

  // Compare path: shadow only reloads while stopped or on the period boundary.
  always_comb begin
    cmp_shadow_d = cmp_shadow_q;
    if (!timer_started || timer_expired) cmp_shadow_d = cmp_value;
    match_d   = ~cap_cmp_sel & timer_started & (timer_cnt_now_v == cmp_shadow_q);
    cmp_itr_d = match_d & ~match_q;
    cmp_out_d = cmp_polarity;
    if (~cap_cmp_sel & timer_started)
      cmp_out_d = (timer_cnt_now_v < cmp_shadow_q) ^ cmp_polarity;
  end

  // Filter runs in both modes so the level is already valid on entry to capture.
  always_comb begin
    s1_d       = cap_in;
    s2_d       = s1_q;
    filt_lvl_d = filt_lvl_q;
    fcnt_d     = fcnt_q;
    toggle     = 1'b0;
    if (s2_q == filt_lvl_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == cap_filter_th) begin
      filt_lvl_d = s2_q;
      fcnt_d     = '0;
      toggle     = 1'b1;
    end else begin
      fcnt_d = fcnt_q + filter_width'(1);
    end
  end

  always_comb begin
    case (cap_edge_type)
      2'b00:   edge_hit = toggle & s2_q;
      2'b01:   edge_hit = toggle & ~s2_q;
      2'b10:   edge_hit = toggle;
      default: edge_hit = 1'b0;
    endcase
    cap_evt = edge_hit & cap_cmp_sel & timer_started;
  end

  // A capture beats a simultaneous clear; overrun stays set until cleared.
  always_comb begin
    cap_value_d   = cap_value_q;
    cap_pending_d = cap_pending_q;
    cap_ovr_d     = cap_ovr_q;
    cap_itr_d     = cap_evt;
    if (cap_evt) begin
      cap_value_d   = timer_cnt_now_v;
      cap_pending_d = 1'b1;
      cap_ovr_d     = cap_ovr_q | cap_pending_q;
    end else if (cap_clr) begin
      cap_pending_d = 1'b0;
      cap_ovr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmp_shadow_q  <= '0;
      cmp_out_q     <= 1'b0;
      match_q       <= 1'b0;
      cmp_itr_q     <= 1'b0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      fcnt_q        <= '0;
      filt_lvl_q    <= 1'b0;
      cap_value_q   <= '0;
      cap_pending_q <= 1'b0;
      cap_ovr_q     <= 1'b0;
      cap_itr_q     <= 1'b0;
    end else begin
      cmp_shadow_q  <= cmp_shadow_d;
      cmp_out_q     <= cmp_out_d;
      match_q       <= match_d;
      cmp_itr_q     <= cmp_itr_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      fcnt_q        <= fcnt_d;
      filt_lvl_q    <= filt_lvl_d;
      cap_value_q   <= cap_value_d;
      cap_pending_q <= cap_pending_d;
      cap_ovr_q     <= cap_ovr_d;
      cap_itr_q     <= cap_itr_d;
    end
  end

  assign cmp_out     = cmp_out_q;
  assign cmp_itr_req = cmp_itr_q;
  assign cap_value   = cap_value_q;
  assign cap_pending = cap_pending_q;
  assign cap_ovr     = cap_ovr_q;
  assign cap_itr_req = cap_itr_q;

endmodule

// File: tb/tb_timer_cap_cmp_chn.sv
// Directed bench for timer_cap_cmp_chn: expected captures/compare samples are queued as stimulus
// is applied and popped when the DUT produces them.
module tb_timer_cap_cmp_chn;
  localparam int TW = 16;
  localparam int FW = 8;
  localparam logic [TW-1:0] AUTOLOAD = 16'd9;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          timer_started = 1'b0;
  logic          timer_expired = 1'b0;
  logic [TW-1:0] timer_cnt_now_v = '0;
  logic          cap_cmp_sel = 1'b0;
  logic [TW-1:0] cmp_value = '0;
  logic          cmp_polarity = 1'b0;
  logic          cap_in = 1'b0;
  logic [1:0]    cap_edge_type = 2'b00;
  logic [FW-1:0] cap_filter_th = '0;
  logic          cap_clr = 1'b0;
  logic          cmp_out;
  logic [TW-1:0] cap_value;
  logic          cap_pending;
  logic          cap_ovr;
  logic          cmp_itr_req;
  logic          cap_itr_req;

  timer_cap_cmp_chn #(.timer_width(TW), .filter_width(FW), .simulation_delay(1)) dut (
    .clk(clk), .resetn(resetn), .timer_started(timer_started), .timer_expired(timer_expired),
    .timer_cnt_now_v(timer_cnt_now_v), .cap_cmp_sel(cap_cmp_sel), .cmp_value(cmp_value),
    .cmp_polarity(cmp_polarity), .cap_in(cap_in), .cap_edge_type(cap_edge_type),
    .cap_filter_th(cap_filter_th), .cap_clr(cap_clr), .cmp_out(cmp_out), .cap_value(cap_value),
    .cap_pending(cap_pending), .cap_ovr(cap_ovr), .cmp_itr_req(cmp_itr_req), .cap_itr_req(cap_itr_req)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int hi_cnt = 0;
  int itr_cnt = 0;
  logic [TW-1:0] cnt = '0;
  logic [TW-1:0] m_shadow = '0;
  logic          m_match_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture-phase cycle: free-running count, pop an expected value on every capture pulse.
  task automatic step();
    tick();
    if (cap_itr_req) begin
      pulses++;
      sb_pop(32'(cap_value));
    end
    cnt = cnt + 16'd1;
    timer_cnt_now_v = cnt;
  endtask

  // Compare-phase cycle: 0..AUTOLOAD up-counter with an expected-output model.
  task automatic pwm_cycle();
    logic m_match, exp_out;
    exp_out = (!cap_cmp_sel && timer_started) ? ((timer_cnt_now_v < m_shadow) ^ cmp_polarity) : cmp_polarity;
    m_match = !cap_cmp_sel && timer_started && (timer_cnt_now_v == m_shadow);
    sb_push("cmp_out", 32'(exp_out));
    sb_push("cmp_itr_req", 32'(m_match && !m_match_d));
    if (!timer_started || timer_expired) m_shadow = cmp_value;
    m_match_d = m_match;
    tick();
    sb_pop(32'(cmp_out));
    sb_pop(32'(cmp_itr_req));
    hi_cnt  += int'(cmp_out);
    itr_cnt += int'(cmp_itr_req);
    if (timer_started) cnt = (cnt == AUTOLOAD) ? 16'd0 : cnt + 16'd1;
    timer_cnt_now_v = cnt;
    timer_expired = timer_started && (cnt == AUTOLOAD);
  endtask

  task automatic pwm_run(input int n);
    repeat (n) pwm_cycle();
  endtask

  task automatic period_chk(input string tag, input int exp_hi, input int exp_itr);
    chk({tag, "_hi"}, 32'(hi_cnt), 32'(exp_hi));
    chk({tag, "_itr"}, 32'(itr_cnt), 32'(exp_itr));
    hi_cnt = 0;
    itr_cnt = 0;
  endtask

  initial begin
    // Reset with compare mode active, inverted polarity and the pin high.
    resetn = 1'b0; cap_in = 1'b1; timer_started = 1'b1; cap_cmp_sel = 1'b0;
    cmp_polarity = 1'b1; cmp_value = 16'd5; cnt = 16'h0050; timer_cnt_now_v = cnt;
    tick(); tick();
    chk("rst_cmp_out", 32'(cmp_out), 32'd0);
    chk("rst_cap_value", 32'(cap_value), 32'd0);
    chk("rst_cap_pending", 32'(cap_pending), 32'd0);
    chk("rst_cap_ovr", 32'(cap_ovr), 32'd0);
    chk("rst_cmp_itr", 32'(cmp_itr_req), 32'd0);
    chk("rst_cap_itr", 32'(cap_itr_req), 32'd0);

    // Rising capture, th=2: pin already high, count 0x40 in the cycle before edge k+4.
    resetn = 1'b1; cap_cmp_sel = 1'b1; cap_edge_type = 2'b00; cap_filter_th = 8'd2;
    cnt = 16'h003C; timer_cnt_now_v = cnt;
    sb_push("cap_value_A", 32'h0040);
    repeat (4) step();
    chk("capA_not_early", 32'(pulses), 32'd0);
    step();
    chk("capA_itr", 32'(cap_itr_req), 32'd1);
    chk("capA_pending", 32'(cap_pending), 32'd1);
    chk("capA_ovr", 32'(cap_ovr), 32'd0);
    step();
    chk("capA_single_pulse", 32'(cap_itr_req), 32'd0);

    // th=4: settle low (falling edge ignored), then a 3-cycle glitch must be rejected.
    cap_filter_th = 8'd4; cap_in = 1'b0;
    repeat (10) step();
    chk("fall_ignored", 32'(pulses), 32'd1);
    cap_in = 1'b1; repeat (3) step(); cap_in = 1'b0;
    repeat (12) step();
    chk("glitch_no_cap", 32'(pulses), 32'd1);
    chk("glitch_ovr", 32'(cap_ovr), 32'd0);

    // Second capture while still pending sets overrun.
    cap_in = 1'b1;
    sb_push("cap_value_C", 32'(cnt) + 32'd6);
    repeat (10) step();
    chk("capC_count", 32'(pulses), 32'd2);
    chk("capC_pending", 32'(cap_pending), 32'd1);
    chk("capC_ovr", 32'(cap_ovr), 32'd1);

    // Clear coincident with a capture: the capture wins.
    cap_in = 1'b0;
    repeat (10) step();
    cap_in = 1'b1;
    sb_push("cap_value_G", 32'(cnt) + 32'd6);
    repeat (6) step();
    chk("capG_not_yet", 32'(pulses), 32'd2);
    cap_clr = 1'b1; step(); cap_clr = 1'b0;
    chk("capG_count", 32'(pulses), 32'd3);
    chk("capG_pending", 32'(cap_pending), 32'd1);
    chk("capG_ovr", 32'(cap_ovr), 32'd1);

    // Clear alone.
    cap_clr = 1'b1; step(); cap_clr = 1'b0;
    chk("clr_pending", 32'(cap_pending), 32'd0);
    chk("clr_ovr", 32'(cap_ovr), 32'd0);

    // Edge type 11: no captures across a full pulse.
    cap_edge_type = 2'b11;
    cap_in = 1'b0; repeat (10) step();
    cap_in = 1'b1; repeat (10) step();
    cap_in = 1'b0; repeat (10) step();
    chk("edge_none", 32'(pulses), 32'd3);

    // Both edges: two captures per clean pulse.
    cap_edge_type = 2'b10;
    cap_in = 1'b1; sb_push("cap_value_E_rise", 32'(cnt) + 32'd6);
    repeat (10) step();
    cap_in = 1'b0; sb_push("cap_value_E_fall", 32'(cnt) + 32'd6);
    repeat (10) step();
    chk("edge_both", 32'(pulses), 32'd5);
    chk("edge_both_ovr", 32'(cap_ovr), 32'd1);
    chk("cap_sb_drained", 32'(sbq.size()), 32'd0);

    // Compare mode: stop the timer so the shadow takes cmp_value=3.
    cap_cmp_sel = 1'b0; timer_started = 1'b0; timer_expired = 1'b0;
    cmp_value = 16'd3; cmp_polarity = 1'b0;
    tick(); tick();
    m_shadow = 16'd3; m_match_d = 1'b0;
    cnt = '0; timer_cnt_now_v = cnt; timer_started = 1'b1; timer_expired = 1'b0;
    hi_cnt = 0; itr_cnt = 0;
    pwm_run(10); period_chk("p1_duty3", 3, 1);
    pwm_run(5); cmp_value = 16'd7; pwm_run(5); period_chk("p2_midchange", 3, 1);
    cmp_value = 16'd0; pwm_run(10); period_chk("p3_duty7", 7, 1);
    cmp_value = 16'd12; cmp_polarity = 1'b1; pwm_run(10); period_chk("p4_zero_inv", 10, 1);
    cmp_polarity = 1'b0; pwm_run(10); period_chk("p5_above_autoload", 10, 0);
    timer_started = 1'b0; timer_expired = 1'b0; pwm_run(3); period_chk("stopped", 0, 0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_cap_cmp_chn.md
Name: timer_cap_cmp_chn

Overview:
- One capture/compare channel for the APB timer. Sits directly downstream of the basic timer and consumes its live count and overflow indication.
- Compare mode: generates a PWM/compare output plus a match interrupt.
- Capture mode: synchronises and filters an external pin, then latches the timer count on a selected edge and raises a capture interrupt.
- Several instances share one timer. Register-file access is owned by the APB wrapper.

Parameters:
- timer_width, 16, width of timer count and compare/capture values (8~32)
- filter_width, 8, width of capture glitch-filter threshold
- simulation_delay, 1, simulation-only delay on sequential assignments

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- timer_started  in  1  timer running
- timer_expired  in  1  timer overflow pulse (period boundary)
- timer_cnt_now_v  in  timer_width  current timer count
- cap_cmp_sel  in  1  1 = capture mode, 0 = compare mode
- cmp_value  in  timer_width  compare value (software side)
- cmp_polarity  in  1  compare output inversion
- cap_in  in  1  asynchronous capture pin
- cap_edge_type  in  2  00 rising, 01 falling, 10 both, 11 none
- cap_filter_th  in  filter_width  extra stable cycles required
- cap_clr  in  1  pulse: clear cap_pending and cap_ovr
- cmp_out  out  1  compare/PWM output
- cap_value  out  timer_width  latched count
- cap_pending  out  1  capture not yet acknowledged
- cap_ovr  out  1  capture overrun flag
- cmp_itr_req  out  1  compare match interrupt pulse
- cap_itr_req  out  1  capture interrupt pulse

Behaviour:
- Reset (resetn low at a clk edge): all outputs 0; all internal registers 0.
  - Synchronous filter level resets to 0.
  - Reset mid-capture discards any in-flight filter count.

Compare shadow:
- cmp_shadow loads cmp_value on any edge where ~timer_started or timer_expired.
- cmp_value changes mid-period take effect only at the next period boundary.

Compare output:
- Registered, 1-cycle latency.
- In compare mode with timer_started: cmp_out <= (timer_cnt_now_v < cmp_shadow) ^ cmp_polarity.
- Otherwise: cmp_out <= cmp_polarity.
- Boundary cases:
  - cmp_shadow = 0 gives a constant cmp_polarity (0% duty).
  - cmp_shadow above the autoload value gives constant ~cmp_polarity.
- Down-counting needs no special handling; the same comparison applies.

Compare match:
- match = compare mode & timer_started & (timer_cnt_now_v == cmp_shadow).
- cmp_itr_req <= match & ~match_d, where match_d is match registered one cycle.
- Result: exactly one 1-cycle pulse per entry into the matching value, even when the prescaler holds the count for many cycles.

Capture synchroniser:
- Two-flop synchroniser: s1 <= cap_in, s2 <= s1.

Capture filter:
- Stability counter fcnt (filter_width bits) compares s2 against filt_lvl.
- If s2 == filt_lvl: fcnt <= 0.
- Else if fcnt == cap_filter_th: filt_lvl <= s2 and fcnt <= 0.
- Else: fcnt <= fcnt + 1.
- Any glitch shorter than cap_filter_th+1 cycles is rejected.

Capture edge and latch:
- Edge event occurs on the cycle filt_lvl toggles, qualified by cap_edge_type.
- On a qualified event with capture mode & timer_started, at the same edge:
  - cap_value <= timer_cnt_now_v (value present in the cycle before that edge).
  - cap_itr_req <= 1 for exactly one cycle.
  - cap_pending <= 1.
  - cap_ovr <= cap_pending, i.e. it sets if a previous capture was still pending; it is sticky.
- Latency: cap_in first sampled high at edge k gives cap_value/cap_itr_req valid after edge k+2+cap_filter_th.

Simultaneous events:
- cap_clr together with a capture event: the capture wins; cap_pending = 1, cap_ovr unchanged by the clear.
- cap_clr alone: cap_pending = 0 and cap_ovr = 0 on the next edge.

Mode and timer state:
- Mode change takes effect at the next edge. The filter keeps running in both modes, so filt_lvl is valid on entry to capture mode.
- When timer_started = 0: no captures and no compare interrupts.

Test Plan:
- Reset: resetn = 0 with cap_in = 1 and compare mode active -> all outputs 0 after the edge; after release, filt_lvl follows cap_in only after 3+th cycles.
- PWM, up-count 0..9, prescale 0, cmp_value = 3, polarity 0 -> cmp_out high for 3 of every 10 cycles. One cmp_itr_req pulse per period, one cycle after the count reaches 3.
- Shadow update: change cmp_value from 3 to 7 mid-period -> duty stays 3 until the next timer_expired, then becomes 7. Also check cmp_value = 0 -> cmp_out stuck at polarity.
- Capture, rising edge, th = 2: count is 0x0040 in the cycle before edge k+4 and cap_in rises before edge k -> cap_value = 0x0040, a single cap_itr_req pulse, cap_pending = 1.
- Filter and edge select, th = 4: a 3-cycle high glitch -> no capture. Edge type both -> two captures per clean pulse. Edge type 11 -> none.
- Overrun and clear:
  - Two captures without cap_clr -> cap_ovr = 1.
  - cap_clr alone -> cap_pending and cap_ovr both 0.
  - cap_clr coincident with a capture -> cap_pending stays 1.
